// File: rtl/ctrl_pkg.sv
// Shared control-unit definitions: T-state and M-cycle encodings, key opcodes,
// and the sequencer state type.
package ctrl_pkg;

    // One-hot T-state encodings (bit0 = T1 .. bit3 = T4)
    localparam logic [3:0] STEP_T1 = 4'b0001;
    localparam logic [3:0] STEP_T2 = 4'b0010;
    localparam logic [3:0] STEP_T3 = 4'b0100;
    localparam logic [3:0] STEP_T4 = 4'b1000;

    // One-hot M-cycle index of the opcode fetch cycle
    localparam logic [7:0] CYCLE_M1 = 8'h01;

    // Opcodes the sequencer cares about
    localparam logic [7:0] OPC_NOP  = 8'h00;
    localparam logic [7:0] OPC_CB   = 8'hCB;
    localparam logic [7:0] OPC_HALT = 8'h76;

    typedef enum logic {
        SEQ_RUN  = 1'b0,
        SEQ_HALT = 1'b1
    } seq_state_t;

    // Advance the T-state ring by one position, T4 wrapping back to T1
    function automatic logic [3:0] rotate_step(input logic [3:0] step);
        return {step[2:0], step[3]};
    endfunction

endpackage

// File: rtl/opcode_field_decode.sv
// Binary-to-one-hot decoder for an opcode bit field. IN_W=3 gives the 3-to-8
// form used for Y and Z; IN_W=2 gives the 2-to-4 form used for X.
module opcode_field_decode #(
    parameter int IN_W = 3
) (
    input  logic [IN_W-1:0]      field,
    output logic [(1<<IN_W)-1:0] onehot
);

    // Set exactly the bit selected by the field value
    always_comb begin
        onehot        = '0;
        onehot[field] = 1'b1;
    end

endmodule

// File: rtl/cycle_sequencer.sv
// Timing/fetch stage of the control unit. Produces the one-hot T-state and
// M-cycle index, holds the instruction register and CB-page flag, and runs
// the RUN/HALT state machine. X/Y/Z are zero-latency decodes of the IR.
module cycle_sequencer
    import ctrl_pkg::*;
#(
    parameter logic [7:0] RESET_OPCODE = OPC_NOP,
    parameter logic [7:0] CB_OPCODE    = OPC_CB
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Wait,
    input  logic       i_IR_Fetch,
    input  logic       i_Halt,
    input  logic       i_Int_Pending,
    input  logic [7:0] i_Data_Bus,
    output logic [3:0] o_Cycle_Step,
    output logic [7:0] o_Cycle_Count,
    output logic [7:0] o_IR,
    output logic [3:0] o_X,
    output logic [7:0] o_Y,
    output logic [7:0] o_Z,
    output logic       o_CB_Prefix,
    output logic       o_M_Cycle_End,
    output logic       o_Halted,
    output logic       o_Overrun
);

    seq_state_t state_q, state_d;
    logic [3:0] step_q, step_d;
    logic [7:0] count_q, count_d;
    logic [7:0] ir_q, ir_d;
    logic       cb_q, cb_d;
    logic       overrun_q, overrun_d;

    // Sequencing state register; reset aborts any instruction in progress
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= SEQ_RUN;
            step_q    <= STEP_T1;
            count_q   <= CYCLE_M1;
            ir_q      <= RESET_OPCODE;
            cb_q      <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            count_q   <= count_d;
            ir_q      <= ir_d;
            cb_q      <= cb_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state logic: step ring, M-cycle shifter, IR/CB load, RUN/HALT control
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        count_d   = count_q;
        ir_d      = ir_q;
        cb_d      = cb_q;
        overrun_d = overrun_q;

        unique case (state_q)
            SEQ_RUN: begin
                // A memory wait freezes everything, including decoder requests
                if (!i_Wait) begin
                    step_d = rotate_step(step_q);
                    if (step_q[3]) begin
                        if (i_Halt) begin
                            // HALT takes priority over a fetch; IR and count hold
                            state_d = SEQ_HALT;
                        end else if (i_IR_Fetch) begin
                            ir_d    = i_Data_Bus;
                            count_d = CYCLE_M1;
                            // A prefix only arms when it is itself a main-page opcode
                            cb_d    = (ir_q == CB_OPCODE) && !cb_q;
                        end else if (count_q[7]) begin
                            // Ran out of M-cycles without a fetch: wrap and flag it
                            count_d   = CYCLE_M1;
                            overrun_d = 1'b1;
                        end else begin
                            count_d = count_q << 1;
                        end
                    end
                end
            end
            SEQ_HALT: begin
                // Step is parked at T1 so the decoders never see a step-3 request
                step_d = STEP_T1;
                if (i_Int_Pending) begin
                    // Resume with a NOP that fetches on its M1 step 3
                    state_d = SEQ_RUN;
                    ir_d    = RESET_OPCODE;
                    count_d = CYCLE_M1;
                    cb_d    = 1'b0;
                end
            end
            default: state_d = SEQ_RUN;
        endcase
    end

    opcode_field_decode #(.IN_W(2)) u_dec_x (.field(ir_q[7:6]), .onehot(o_X));
    opcode_field_decode #(.IN_W(3)) u_dec_y (.field(ir_q[5:3]), .onehot(o_Y));
    opcode_field_decode #(.IN_W(3)) u_dec_z (.field(ir_q[2:0]), .onehot(o_Z));

    assign o_Cycle_Step  = step_q;
    assign o_Cycle_Count = count_q;
    assign o_IR          = ir_q;
    assign o_CB_Prefix   = cb_q;
    assign o_Halted      = (state_q == SEQ_HALT);
    assign o_Overrun     = overrun_q;
    assign o_M_Cycle_End = step_q[3] && !i_Wait && (state_q != SEQ_HALT);

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer with hand-computed expected values.
module tb_cycle_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       wait_r, fetch, halt, intp;
    logic [7:0] bus;
    logic [3:0] step;
    logic [7:0] count, ir, y, z;
    logic [3:0] x;
    logic       cb, mend, halted, ovr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cycle_sequencer dut (
        .i_Clk         (clk),
        .i_Reset       (rst),
        .i_Wait        (wait_r),
        .i_IR_Fetch    (fetch),
        .i_Halt        (halt),
        .i_Int_Pending (intp),
        .i_Data_Bus    (bus),
        .o_Cycle_Step  (step),
        .o_Cycle_Count (count),
        .o_IR          (ir),
        .o_X           (x),
        .o_Y           (y),
        .o_Z           (z),
        .o_CB_Prefix   (cb),
        .o_M_Cycle_End (mend),
        .o_Halted      (halted),
        .o_Overrun     (ovr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-hot invariants sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            check("step_onehot",  {31'b0, $onehot(step)},  32'd1);
            check("count_onehot", {31'b0, $onehot(count)}, 32'd1);
            check("x_onehot",     {31'b0, $onehot(x)},     32'd1);
            check("y_onehot",     {31'b0, $onehot(y)},     32'd1);
            check("z_onehot",     {31'b0, $onehot(z)},     32'd1);
        end
    end

    initial begin
        rst = 1'b1; wait_r = 1'b0; fetch = 1'b0; halt = 1'b0; intp = 1'b0; bus = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_step",  step,  4'b0001);
        check("rst_count", count, 8'h01);
        check("rst_ir",    ir,    8'h00);
        check("rst_flags", {cb, halted, ovr}, 3'b000);

        // 1: fetch 8'h41 on the first step 3
        fetch = 1'b1; bus = 8'h41;
        tick(4);
        check("t1_ir",    ir,    8'h41);
        check("t1_x",     x,     4'h2);
        check("t1_y",     y,     8'h01);
        check("t1_z",     z,     8'h02);
        check("t1_count", count, 8'h01);
        check("t1_step",  step,  4'b0001);
        check("t1_cb",    cb,    1'b0);

        // 2: two M-cycles without fetch, fetch at end of the third
        fetch = 1'b0; bus = 8'h00;
        tick(4);
        check("t2_count2", count, 8'h02);
        tick(4);
        check("t2_count4", count, 8'h04);
        tick(3);
        check("t2_step3", step, 4'b1000);
        check("t2_mend",  mend, 1'b1);
        fetch = 1'b1;
        tick(1);
        check("t2_count1", count, 8'h01);
        check("t2_ir",     ir,    8'h00);
        check("t2_ovr",    ovr,   1'b0);

        // 3: wait stall at step 2, fetch request ignored while stalled
        fetch = 1'b0;
        tick(2);
        check("t3_step2", step, 4'b0100);
        wait_r = 1'b1; fetch = 1'b1; bus = 8'hFF;
        tick(5);
        check("t3_frz_step",  step,  4'b0100);
        check("t3_frz_count", count, 8'h01);
        check("t3_frz_ir",    ir,    8'h00);
        tick(1);
        check("t3_frz_step_b", step, 4'b0100);
        wait_r = 1'b0; fetch = 1'b0;
        tick(1);
        check("t3_resume", step, 4'b1000);
        wait_r = 1'b1;
        #1 check("t3_mend_wait", mend, 1'b0);
        wait_r = 1'b0;

        // 4: HALT wins over fetch at step 3
        halt = 1'b1; fetch = 1'b1; bus = 8'h55;
        tick(1);
        halt = 1'b0; fetch = 1'b0;
        check("t4_halted", halted, 1'b1);
        check("t4_ir",     ir,     8'h00);
        check("t4_count",  count,  8'h01);
        wait_r = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("t4_hold_step", step,   4'b0001);
            check("t4_hold_halt", halted, 1'b1);
            check("t4_hold_mend", mend,   1'b0);
        end
        wait_r = 1'b0;
        intp = 1'b1;
        tick(1);
        intp = 1'b0;
        check("t4_exit_halt", halted, 1'b0);
        check("t4_exit_ir",   ir,     8'h00);
        check("t4_exit_step", step,   4'b0001);
        fetch = 1'b1; bus = 8'hCB;
        tick(4);
        check("t4_fetch_ir", ir, 8'hCB);
        check("t4_fetch_cb", cb, 1'b0);

        // 5: CB prefix arming, and a CB-page CB not re-arming it
        bus = 8'h37;
        tick(4);
        check("t5_ir37", ir, 8'h37);
        check("t5_cb1",  cb, 1'b1);
        bus = 8'hCB;
        tick(4);
        check("t5_cb_after37", cb, 1'b0);
        tick(4);
        check("t5_cbcb_ir", ir, 8'hCB);
        check("t5_cbcb_cb", cb, 1'b1);
        bus = 8'h00;
        tick(4);
        check("t5_norearm", cb, 1'b0);

        // 6: count wraps past 8'h80 without fetch, then async reset mid-step
        fetch = 1'b0;
        tick(28);
        check("t6_count80", count, 8'h80);
        check("t6_ovr0",    ovr,   1'b0);
        tick(4);
        check("t6_wrap", count, 8'h01);
        check("t6_ovr1", ovr,   1'b1);
        tick(4);
        check("t6_ovr_sticky", ovr, 1'b1);
        tick(2);
        check("t6_step2", step, 4'b0100);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_step",  step,  4'b0001);
        check("t6_rst_count", count, 8'h01);
        check("t6_rst_ir",    ir,    8'h00);
        check("t6_rst_flags", {cb, halted, ovr}, 3'b000);
        check("t6_rst_xyz",   {x, y, z}, {4'h1, 8'h01, 8'h01});
        #1 rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
